// File: rtl/fsa_frame_scan_if.sv
// AXI4-Stream video link for fsa_frame_scan: tdata plus tuser (SOF) and tlast (EOL).
// The master modport drives the beat and the slave modport returns tready.
interface fsa_frame_scan_if #(
  parameter int DW = 8
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/fsa_frame_scan.sv
// fsa_frame_scan: classifies pixels against ref_data and measures the per-frame dark column extent.
// Optional feature macro FSA_FRAME_SCAN_HYST_EN adds ref_hyst and an in-row hysteresis threshold.
module fsa_frame_scan #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WW      = 12,
  parameter int C_IMG_HW      = 12,
  parameter int C_TEST        = 12,
  parameter int C_OUT_DW      = 2,
  parameter logic [C_OUT_DW-1:0] C_OUT_DV = 2'b10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [C_IMG_WW-1:0]      width,
  input  logic [C_IMG_HW-1:0]      height,
  input  logic [C_PIXEL_WIDTH-1:0] ref_data,
`ifdef FSA_FRAME_SCAN_HYST_EN
  input  logic [C_PIXEL_WIDTH-1:0] ref_hyst,
`endif
  input  logic                     fsync,
  fsa_frame_scan_if.slave          s_axis,
  fsa_frame_scan_if.master         m_axis,
  output logic [C_IMG_WW-1:0]      lft_v,
  output logic [C_IMG_WW-1:0]      rt_v,
  output logic                     res_valid,
  output logic                     res_empty,
  output logic                     geo_err
);
  localparam int BW = C_TEST + C_OUT_DW + 2;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [C_IMG_WW-1:0] COL_ONE = {{(C_IMG_WW-1){1'b0}}, 1'b1};
  localparam logic [C_IMG_HW-1:0] ROW_ONE = {{(C_IMG_HW-1){1'b0}}, 1'b1};

`ifdef FSA_FRAME_SCAN_HYST_EN
  function automatic logic [C_PIXEL_WIDTH-1:0] sat_add(input logic [C_PIXEL_WIDTH-1:0] a,
                                                       input logic [C_PIXEL_WIDTH-1:0] b);
    logic [C_PIXEL_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[C_PIXEL_WIDTH] ? {C_PIXEL_WIDTH{1'b1}} : sum[C_PIXEL_WIDTH-1:0];
  endfunction
  logic hyst_r;
`endif

  logic [1:0]               state_r, state_nx_s, after_s;
  logic [C_IMG_WW-1:0]      col_r, w_r, lmin_r, rmax_r;
  logic [C_IMG_HW-1:0]      row_r, h_r;
  logic                     any_r, err_r, arm_pend_r;
  logic [BW-1:0]            head_r, tail_r;
  logic                     head_v_r, tail_v_r;

  logic                     accept_s, start_s, restart_s, proc_s, new_s, last_s, dark_s, geo_bad_s;
  logic                     pop_s, any_nx_s, err_nx_s;
  logic [C_IMG_WW-1:0]      eff_col_s, eff_w_s, lmin_base_s, rmax_base_s, lmin_nx_s, rmax_nx_s;
  logic [C_IMG_HW-1:0]      eff_row_s, eff_h_s;
  logic [C_PIXEL_WIDTH-1:0] thr_s;
  logic [C_TEST-1:0]        pix_ext_s;
  logic [BW-1:0]            beat_s;

  assign s_axis.tready = (state_r == ST_IDLE) ? 1'b1 : ~(head_v_r & tail_v_r);
  assign m_axis.tvalid = head_v_r;
  assign m_axis.tuser  = head_r[BW-1];
  assign m_axis.tlast  = head_r[BW-2];
  assign m_axis.tdata  = head_r[BW-3:0];

  // Beat classification, frame position and running extent for the beat being accepted
  always_comb begin
    accept_s  = s_axis.tvalid & s_axis.tready;
    start_s   = accept_s & s_axis.tuser & (state_r == ST_WAIT_SOF);
    restart_s = accept_s & s_axis.tuser & (state_r == ST_RUN) &
                ((row_r != {C_IMG_HW{1'b0}}) | (col_r != {C_IMG_WW{1'b0}}));
    proc_s    = start_s | (accept_s & (state_r == ST_RUN));
    new_s     = start_s | restart_s;
    eff_col_s = new_s ? {C_IMG_WW{1'b0}} : col_r;
    eff_row_s = new_s ? {C_IMG_HW{1'b0}} : row_r;
    eff_w_s   = new_s ? width : w_r;
    eff_h_s   = new_s ? height : h_r;
`ifdef FSA_FRAME_SCAN_HYST_EN
    // Hysteresis only carries within a row; column 0 always uses the plain threshold
    thr_s = (hyst_r && (eff_col_s != {C_IMG_WW{1'b0}})) ? sat_add(ref_data, ref_hyst) : ref_data;
`else
    thr_s = ref_data;
`endif
    dark_s      = s_axis.tdata < thr_s;
    geo_bad_s   = s_axis.tlast ? (eff_col_s != (eff_w_s - COL_ONE)) : (eff_col_s == (eff_w_s - COL_ONE));
    last_s      = s_axis.tlast & (eff_row_s == (eff_h_s - ROW_ONE));
    lmin_base_s = new_s ? {C_IMG_WW{1'b1}} : lmin_r;
    rmax_base_s = new_s ? {C_IMG_WW{1'b0}} : rmax_r;
    lmin_nx_s   = (dark_s && (eff_col_s < lmin_base_s)) ? eff_col_s : lmin_base_s;
    rmax_nx_s   = (dark_s && (eff_col_s > rmax_base_s)) ? eff_col_s : rmax_base_s;
    any_nx_s    = (new_s ? 1'b0 : any_r) | dark_s;
    err_nx_s    = (new_s ? 1'b0 : err_r) | geo_bad_s;
    pix_ext_s   = {C_TEST{1'b0}};
    pix_ext_s[C_PIXEL_WIDTH-1:0] = s_axis.tdata;
    beat_s      = {new_s | ((eff_row_s == {C_IMG_HW{1'b0}}) & (eff_col_s == {C_IMG_WW{1'b0}})),
                   s_axis.tlast, pix_ext_s, dark_s ? C_OUT_DV : {C_OUT_DW{1'b0}}};
    pop_s       = head_v_r & m_axis.tready;
  end

  // Next-state selection for the arming FSM
  always_comb begin
    after_s = (arm_pend_r | fsync) ? ST_WAIT_SOF : ST_IDLE;
    case (state_r)
      ST_IDLE:     state_nx_s = fsync ? ST_WAIT_SOF : ST_IDLE;
      ST_WAIT_SOF: state_nx_s = start_s ? (last_s ? after_s : ST_RUN) : ST_WAIT_SOF;
      ST_RUN:      state_nx_s = (proc_s && last_s) ? after_s : ST_RUN;
      default:     state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state, frame counters and extent accumulators
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      col_r      <= {C_IMG_WW{1'b0}};
      row_r      <= {C_IMG_HW{1'b0}};
      w_r        <= {C_IMG_WW{1'b0}};
      h_r        <= {C_IMG_HW{1'b0}};
      lmin_r     <= {C_IMG_WW{1'b1}};
      rmax_r     <= {C_IMG_WW{1'b0}};
      any_r      <= 1'b0;
      err_r      <= 1'b0;
      arm_pend_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (proc_s && last_s) begin
        arm_pend_r <= 1'b0;
      end else if ((state_r == ST_RUN) && fsync) begin
        arm_pend_r <= 1'b1;
      end
      if (proc_s) begin
        w_r    <= eff_w_s;
        h_r    <= eff_h_s;
        lmin_r <= lmin_nx_s;
        rmax_r <= rmax_nx_s;
        any_r  <= any_nx_s;
        err_r  <= err_nx_s;
        if (last_s) begin
          col_r <= {C_IMG_WW{1'b0}};
          row_r <= {C_IMG_HW{1'b0}};
        end else if (s_axis.tlast) begin
          col_r <= {C_IMG_WW{1'b0}};
          row_r <= eff_row_s + ROW_ONE;
        end else begin
          col_r <= eff_col_s + COL_ONE;
          row_r <= eff_row_s;
        end
      end
    end
  end

`ifdef FSA_FRAME_SCAN_HYST_EN
  // Previous-pixel dark state for the hysteresis threshold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hyst_r <= 1'b0;
    end else if (proc_s) begin
      hyst_r <= dark_s;
    end
  end
`endif

  // Result latch: completed frame, or the frame cut short by an early SOF
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lft_v     <= {C_IMG_WW{1'b0}};
      rt_v      <= {C_IMG_WW{1'b0}};
      res_valid <= 1'b0;
      res_empty <= 1'b0;
      geo_err   <= 1'b0;
    end else if (proc_s && last_s) begin
      lft_v     <= any_nx_s ? lmin_nx_s : {C_IMG_WW{1'b0}};
      rt_v      <= any_nx_s ? rmax_nx_s : {C_IMG_WW{1'b0}};
      res_valid <= 1'b1;
      res_empty <= ~any_nx_s;
      geo_err   <= err_nx_s;
    end else if (restart_s) begin
      lft_v     <= any_r ? lmin_r : {C_IMG_WW{1'b0}};
      rt_v      <= any_r ? rmax_r : {C_IMG_WW{1'b0}};
      res_valid <= 1'b1;
      res_empty <= ~any_r;
      geo_err   <= 1'b1;
    end else begin
      res_valid <= 1'b0;
    end
  end

  // Two-entry output skid: head drives m_axis, tail absorbs one beat while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r   <= {BW{1'b0}};
      tail_r   <= {BW{1'b0}};
      head_v_r <= 1'b0;
      tail_v_r <= 1'b0;
    end else if (pop_s) begin
      if (tail_v_r) begin
        head_r   <= tail_r;
        tail_v_r <= proc_s;
        if (proc_s) begin
          tail_r <= beat_s;
        end
      end else begin
        head_v_r <= proc_s;
        if (proc_s) begin
          head_r <= beat_s;
        end
      end
    end else if (proc_s) begin
      if (!head_v_r) begin
        head_r   <= beat_s;
        head_v_r <= 1'b1;
      end else begin
        tail_r   <= beat_s;
        tail_v_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fsa_frame_scan.sv
// Randomized self-checking bench for fsa_frame_scan: a frame-level reference model predicts
// every output beat and every per-frame result; random source gaps and sink back-pressure.
module tb_fsa_frame_scan;
  localparam int PW = 8;
  localparam int WW = 12;
  localparam int HW = 12;
  localparam int MW = 14;
`ifdef FSA_FRAME_SCAN_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [WW-1:0] width;
  logic [HW-1:0] height;
  logic [PW-1:0] ref_data;
`ifdef FSA_FRAME_SCAN_HYST_EN
  logic [PW-1:0] ref_hyst;
`endif
  logic fsync;
  logic [WW-1:0] lft_v, rt_v;
  logic res_valid, res_empty, geo_err;

  fsa_frame_scan_if #(.DW(PW)) s_if ();
  fsa_frame_scan_if #(.DW(MW)) m_if ();

  fsa_frame_scan dut (
    .clk(clk), .resetn(resetn), .width(width), .height(height), .ref_data(ref_data),
`ifdef FSA_FRAME_SCAN_HYST_EN
    .ref_hyst(ref_hyst),
`endif
    .fsync(fsync), .s_axis(s_if), .m_axis(m_if),
    .lft_v(lft_v), .rt_v(rt_v), .res_valid(res_valid), .res_empty(res_empty), .geo_err(geo_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int beat_cnt = 0;
  int res_cnt = 0;
  int ref_v = 128;
  int hyst_v = 0;
  bit rdy_hold = 1'b0;
  logic [MW+1:0] exp_beats[$];
  logic [2*WW+1:0] exp_res[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2*WW+1:0] pack_res(input int l, input int r, input bit e, input bit g);
    return {WW'(l), WW'(r), e, g};
  endfunction

  function automatic logic [PW-1:0] gen_pix(input int mode, input int r, input int c);
    logic [PW-1:0] p;
    case (mode)
      1: p = (((r >= 5 && r <= 7) || (r >= 10 && r <= 15)) && (c <= 17 || c >= 23)) ? 8'd10 : PW'(128 + c);
      2: p = (r >= 2 && r <= 4 && c >= 3 && c <= 30) ? PW'($urandom_range(0, 127)) : PW'(128 + c);
      5: p = 8'd200;
      6: case (c)
           0: p = 8'd50;
           1: p = 8'd130;
           2: p = 8'd140;
           default: p = 8'd150;
         endcase
      default: p = PW'($urandom_range(0, 255));
    endcase
    return p;
  endfunction

  task automatic set_thr(input int r, input int h);
    ref_v = r;
    ref_data = PW'(r);
    hyst_v = HYST ? h : 0;
`ifdef FSA_FRAME_SCAN_HYST_EN
    ref_hyst = PW'(hyst_v);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
  endtask

  task automatic send_beat(input logic [PW-1:0] pix, input logic usr, input logic lst, input bit chk_rdy);
    bit acc;
    int gap;
    acc = 1'b0;
    gap = $urandom_range(0, 2);
    s_if.tvalid = 1'b0;
    repeat (gap) tick();
    s_if.tvalid = 1'b1;
    s_if.tdata = pix;
    s_if.tuser = usr;
    s_if.tlast = lst;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = s_if.tready;
      if (chk_rdy) check("idle_tready", s_if.tready, 1'b1);
      tick();
      if (acc) break;
    end
    if (!acc) check("accept_timeout", acc, 1'b1);
    s_if.tvalid = 1'b0;
  endtask

  // Frame model: each pixel is dark when below ref (or ref+hyst, saturated, right after a dark
  // pixel in the same row); extent is the min/max dark column over all beats of the frame.
  task automatic send_frame(input int w, input int h, input int mode, input bit armed,
                            input int fault_row, input int abort_after);
    int lmin, rmax, nb, rowlen, thr, hi;
    bit anyd, prev, dark, usr, lst;
    logic [PW-1:0] pix;
    lmin = 1 << WW; rmax = -1; nb = 0; anyd = 1'b0; prev = 1'b0;
    width = WW'(w);
    height = HW'(h);
    hi = (ref_v + hyst_v > 255) ? 255 : ref_v + hyst_v;
    for (int r = 0; r < h; r++) begin
      rowlen = (r == fault_row) ? 36 : w;
      for (int c = 0; c < rowlen; c++) begin
        if (abort_after > 0 && nb == abort_after) begin
          if (armed) exp_res.push_back(pack_res(anyd ? lmin : 0, anyd ? rmax : 0, !anyd, 1'b1));
          return;
        end
        pix = gen_pix(mode, r, c);
        thr = (c > 0 && prev) ? hi : ref_v;
        dark = int'(pix) < thr;
        prev = dark;
        usr = (r == 0 && c == 0);
        lst = (c == rowlen - 1);
        if (armed) begin
          exp_beats.push_back({usr, lst, 4'b0000, pix, dark ? 2'b10 : 2'b00});
          if (dark) begin
            anyd = 1'b1;
            if (c < lmin) lmin = c;
            if (c > rmax) rmax = c;
          end
        end
        send_beat(pix, usr, lst, !armed);
        nb++;
      end
    end
    if (armed) exp_res.push_back(pack_res(anyd ? lmin : 0, anyd ? rmax : 0, !anyd, fault_row >= 0));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_res.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_beats_left"}, exp_beats.size(), 0);
    check({tag, "_res_left"}, exp_res.size(), 0);
    repeat (3) tick();
  endtask

  // Sink back-pressure
  initial begin
    m_if.tready = 1'b0;
    forever begin
      tick();
      m_if.tready = rdy_hold ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end

  // Output monitor: beats against the model queue, stall stability, per-frame results
  initial begin
    logic [MW+1:0] cur, held_val;
    bit held_v;
    held_v = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        held_v = 1'b0;
      end else begin
        cur = {m_if.tuser, m_if.tlast, m_if.tdata};
        if (held_v) begin
          check("stall_valid", m_if.tvalid, 1'b1);
          check("stall_data", cur, held_val);
        end
        if (m_if.tvalid && m_if.tready) begin
          beat_cnt++;
          if (exp_beats.size() == 0) check("spurious_beat", m_if.tvalid, 1'b0);
          else check("beat", cur, exp_beats.pop_front());
          held_v = 1'b0;
        end else begin
          held_v = m_if.tvalid;
          held_val = cur;
        end
        if (res_valid) begin
          res_cnt++;
          if (exp_res.size() == 0) check("spurious_res", res_valid, 1'b0);
          else check("res", {lft_v, rt_v, res_empty, geo_err}, exp_res.pop_front());
        end
      end
    end
  end

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    fsync = 1'b0; width = '0; height = '0;
    set_thr(128, 0);
    repeat (3) tick();
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_lft", lft_v, '0);
    check("rst_rt", rt_v, '0);
    check("rst_empty", res_empty, 1'b0);
    check("rst_geo", geo_err, 1'b0);
    check("rst_s_tready", s_if.tready, 1'b1);
    resetn = 1'b1;
    tick();

    repeat (3) send_frame(40, 20, 1, 1'b0, -1, 0);
    drain("t3");

    arm();
    send_frame(40, 20, 1, 1'b1, -1, 0);
    drain("t1");

    res_cnt = 0;
    arm();
    send_beat(8'd5, 1'b0, 1'b0, 1'b0);
    send_beat(8'd5, 1'b0, 1'b1, 1'b0);
    send_beat(8'd200, 1'b0, 1'b0, 1'b0);
    send_frame(40, 20, 2, 1'b1, -1, 0);
    arm();
    send_frame(40, 20, 2, 1'b1, -1, 0);
    drain("t2");
    check("t2_res_count", res_cnt, 2);

    arm();
    send_frame(40, 20, 2, 1'b1, 6, 0);
    arm();
    send_frame(40, 20, 2, 1'b1, -1, 0);
    drain("t4");

    beat_cnt = 0;
    arm();
    send_frame(40, 20, 5, 1'b1, -1, 0);
    drain("t5");
    check("t5_beat_count", beat_cnt, 800);

    for (int i = 0; i < 4; i++) begin
      set_thr($urandom_range(1, 255), $urandom_range(0, 63));
      arm();
      send_frame($urandom_range(2, 24), $urandom_range(1, 8), 0, 1'b1, -1, 0);
      drain("rnd");
    end

    set_thr(128, 20);
    arm();
    send_frame(8, 4, 0, 1'b1, -1, 13);
    send_frame(8, 4, 0, 1'b1, -1, 0);
    drain("abort");

`ifdef FSA_FRAME_SCAN_HYST_EN
    set_thr(128, 16);
    arm();
    send_frame(4, 1, 6, 1'b1, -1, 0);
    drain("t6");
`endif

    set_thr(128, 0);
    rdy_hold = 1'b1;
    arm();
    send_frame(8, 4, 1, 1'b1, -1, 2);
    repeat (2) tick();
    check("pre_rst_tvalid", m_if.tvalid, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_if.tvalid, 1'b0);
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_lft", lft_v, '0);
    exp_beats.delete();
    exp_res.delete();
    tick();
    resetn = 1'b1;
    rdy_hold = 1'b0;
    repeat (3) tick();
    check("post_rst_tvalid", m_if.tvalid, 1'b0);
    check("post_rst_s_tready", s_if.tready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
